// File: rtl/kong_pkg.sv
// Shared types and constants for the Kong game sequencer.
package kong_pkg;

    typedef enum logic [2:0] {
        S_TITLE     = 3'd0,
        S_PLAY      = 3'd1,
        S_DYING     = 3'd2,
        S_LEVEL_UP  = 3'd3,
        S_GAME_OVER = 3'd4
    } game_state_t;

    localparam int unsigned MAX_LIVES       = 7;
    localparam logic [15:0] SCORE_MAX       = 16'h9999;
    localparam logic [15:0] BONUS_THRESHOLD = 16'h0050;

endpackage

// File: rtl/bcd_sat_adder.sv
// Combinational 4-digit BCD adder; a carry out of the top digit saturates to 9999.
module bcd_sat_adder
    import kong_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);

    logic [15:0] raw;
    logic [4:0]  digit;
    logic        carry;

    // Ripple the decimal carry digit by digit, then clamp on overflow.
    always_comb begin
        raw   = '0;
        digit = '0;
        carry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            digit = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'd0, carry};
            if (digit > 5'd9) begin
                digit = digit + 5'd6;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            raw[4*i +: 4] = digit[3:0];
        end
        sum_o = carry ? SCORE_MAX : raw;
    end

endmodule

// File: rtl/game_flow_fsm.sv
// Kong top-level game sequencer: game state, lives, BCD score, freeze/respawn/next_level.
// Optional build macro KONG_BONUS_LIFE_EN grants one extra life per game when the
// score first reaches 0050.
module game_flow_fsm
    import kong_pkg::*;
#(
    parameter int unsigned LIVES_INIT     = 3,
    parameter int unsigned DEATH_FRAMES   = 60,
    parameter int unsigned LEVELUP_FRAMES = 90,
    parameter logic [15:0] ITEM_POINTS    = 16'h0001,
    parameter logic [15:0] WIN_POINTS     = 16'h0010
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start_of_frame_i,
    input  logic        start_key_i,
    input  logic        hit_enemy_i,
    input  logic        hit_item_i,
    input  logic        reached_goal_i,
    output logic [2:0]  state_o,
    output logic        freeze_o,
    output logic        respawn_o,
    output logic        next_level_o,
    output logic [2:0]  lives_o,
    output logic [15:0] score_o,
    output logic        game_over_o
);

    localparam int unsigned FrameMax = (DEATH_FRAMES > LEVELUP_FRAMES) ? DEATH_FRAMES
                                                                         : LEVELUP_FRAMES;
    localparam int unsigned FrameW   = $clog2(FrameMax + 1);

    game_state_t       state_q, state_d;
    logic [2:0]        lives_q, lives_d;
    logic [15:0]       score_q, score_d;
    logic [FrameW-1:0] cnt_q, cnt_d;
    logic              start_q;
    logic              entry_q, entry_d;
    logic              freeze_q, freeze_d;
    logic              respawn_q, respawn_d;
    logic              next_level_q, next_level_d;
    logic              game_over_q, game_over_d;

    logic              start_rise;
    logic [15:0]       incr;
    logic [15:0]       sum;
    logic              bonus_used;
    logic              bonus_grant;

`ifdef KONG_BONUS_LIFE_EN
    logic              bonus_q, bonus_d;
    assign bonus_used = bonus_q;
`else
    assign bonus_used = 1'b1;
`endif

    assign start_rise  = start_key_i & ~start_q;
    // Goal outranks item, so a coincident item never adds to the goal increment.
    assign incr        = reached_goal_i ? WIN_POINTS : ITEM_POINTS;
    assign bonus_grant = ~bonus_used & (score_q < BONUS_THRESHOLD) & (sum >= BONUS_THRESHOLD);

    bcd_sat_adder u_adder (
        .a_i   (score_q),
        .b_i   (incr),
        .sum_o (sum)
    );

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        score_d      = score_q;
        cnt_d        = cnt_q;
        respawn_d    = 1'b0;
        next_level_d = 1'b0;
`ifdef KONG_BONUS_LIFE_EN
        bonus_d      = bonus_q;
`endif

        case (state_q)
            S_TITLE: begin
                if (start_rise) begin
                    state_d   = S_PLAY;
                    lives_d   = 3'(LIVES_INIT);
                    score_d   = '0;
                    respawn_d = 1'b1;
`ifdef KONG_BONUS_LIFE_EN
                    bonus_d   = 1'b0;
`endif
                end
            end
            S_PLAY: begin
                if (hit_enemy_i) begin
                    if (lives_q > 3'd1) begin
                        lives_d = lives_q - 3'd1;
                        state_d = S_DYING;
                    end else begin
                        lives_d = 3'd0;
                        state_d = S_GAME_OVER;
                    end
                end else if (reached_goal_i || hit_item_i) begin
                    score_d = sum;
                    if (reached_goal_i) begin
                        next_level_d = 1'b1;
                        state_d      = S_LEVEL_UP;
                    end
                    if (bonus_grant) begin
                        if (lives_q < 3'(MAX_LIVES)) begin
                            lives_d = lives_q + 3'd1;
                        end
`ifdef KONG_BONUS_LIFE_EN
                        bonus_d = 1'b1;
`endif
                    end
                end
            end
            S_DYING: begin
                // A frame tick on the first cycle of the state is not counted.
                if (start_of_frame_i && !entry_q) begin
                    if (cnt_q == FrameW'(DEATH_FRAMES - 1)) begin
                        state_d   = S_PLAY;
                        respawn_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + FrameW'(1);
                    end
                end
            end
            S_LEVEL_UP: begin
                if (start_of_frame_i && !entry_q) begin
                    if (cnt_q == FrameW'(LEVELUP_FRAMES - 1)) begin
                        state_d   = S_PLAY;
                        respawn_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + FrameW'(1);
                    end
                end
            end
            S_GAME_OVER: begin
                if (start_rise) begin
                    state_d = S_TITLE;
                end
            end
            default: begin
                state_d = S_TITLE;
            end
        endcase

        entry_d = (state_d != state_q);
        if (entry_d) begin
            cnt_d = '0;
        end
        freeze_d    = (state_d != S_PLAY);
        game_over_d = (state_d == S_GAME_OVER);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= S_TITLE;
            lives_q      <= 3'(LIVES_INIT);
            score_q      <= '0;
            cnt_q        <= '0;
            start_q      <= 1'b0;
            entry_q      <= 1'b0;
            freeze_q     <= 1'b1;
            respawn_q    <= 1'b0;
            next_level_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            cnt_q        <= cnt_d;
            start_q      <= start_key_i;
            entry_q      <= entry_d;
            freeze_q     <= freeze_d;
            respawn_q    <= respawn_d;
            next_level_q <= next_level_d;
            game_over_q  <= game_over_d;
        end
    end

`ifdef KONG_BONUS_LIFE_EN
    // Once-per-game bonus flag.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bonus_q <= 1'b0;
        end else begin
            bonus_q <= bonus_d;
        end
    end
`endif

    assign state_o      = state_q;
    assign freeze_o     = freeze_q;
    assign respawn_o    = respawn_q;
    assign next_level_o = next_level_q;
    assign lives_o      = lives_q;
    assign score_o      = score_q;
    assign game_over_o  = game_over_q;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Scoreboard bench for game_flow_fsm: the driver queues expected outputs after each
// stimulus edge; a monitor pops and compares on the following falling edge.
module tb_game_flow_fsm;
    import kong_pkg::*;

`ifdef KONG_BONUS_LIFE_EN
    localparam logic [2:0] BL = 3'd1;
`else
    localparam logic [2:0] BL = 3'd0;
`endif

    logic        clk = 1'b0;
    logic        resetN;
    logic        start_of_frame, start_key, hit_enemy, hit_item, reached_goal;
    logic [2:0]  state;
    logic        freeze, respawn, next_level, game_over;
    logic [2:0]  lives;
    logic [15:0] score;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic        fz;
        logic        rsp;
        logic        nl;
        logic [2:0]  lv;
        logic [15:0] sc;
        logic        go;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    game_flow_fsm dut (
        .clk              (clk),
        .resetN           (resetN),
        .start_of_frame_i (start_of_frame),
        .start_key_i      (start_key),
        .hit_enemy_i      (hit_enemy),
        .hit_item_i       (hit_item),
        .reached_goal_i   (reached_goal),
        .state_o          (state),
        .freeze_o         (freeze),
        .respawn_o        (respawn),
        .next_level_o     (next_level),
        .lives_o          (lives),
        .score_o          (score),
        .game_over_o      (game_over)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input string name, input logic [2:0] st, input logic fz,
                            input logic rsp, input logic nl, input logic [2:0] lv,
                            input logic [15:0] sc, input logic go);
        exp_t e;
        e.name = name; e.st = st; e.fz = fz; e.rsp = rsp; e.nl = nl;
        e.lv = lv; e.sc = sc; e.go = go;
        sb_q.push_back(e);
    endtask

    // One clock of stimulus; pulses are dropped right after the edge, start_key is a level.
    task automatic cyc(input logic sof, input logic he, input logic hi, input logic rg);
        start_of_frame = sof; hit_enemy = he; hit_item = hi; reached_goal = rg;
        @(posedge clk); #1;
        start_of_frame = 1'b0; hit_enemy = 1'b0; hit_item = 1'b0; reached_goal = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic items(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: compare every queued expectation against the outputs on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if ({state, freeze, respawn, next_level, lives, score, game_over} !==
                    {e.st, e.fz, e.rsp, e.nl, e.lv, e.sc, e.go}) begin
                    n_fail++;
                    $display("FAIL %s: got st=%0d fz=%b rsp=%b nl=%b lv=%0d sc=%h go=%b, required st=%0d fz=%b rsp=%b nl=%b lv=%0d sc=%h go=%b",
                             e.name, state, freeze, respawn, next_level, lives, score, game_over,
                             e.st, e.fz, e.rsp, e.nl, e.lv, e.sc, e.go);
                end
            end
        end
    end

    initial begin
        resetN = 1'b0; start_key = 1'b0;
        start_of_frame = 1'b0; hit_enemy = 1'b0; hit_item = 1'b0; reached_goal = 1'b0;
        #1 push_exp("reset", S_TITLE, 1, 0, 0, 3'd3, 16'h0000, 0);
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;

        start_key = 1'b1; cyc(0, 0, 0, 0);
        push_exp("start_play", S_PLAY, 0, 1, 0, 3'd3, 16'h0000, 0);
        cyc(0, 0, 0, 0);
        push_exp("respawn_one_cycle", S_PLAY, 0, 0, 0, 3'd3, 16'h0000, 0);
        start_key = 1'b0; cyc(0, 0, 0, 0);
        start_key = 1'b1; cyc(0, 0, 0, 0);
        push_exp("key_ignored_in_play", S_PLAY, 0, 0, 0, 3'd3, 16'h0000, 0);

        items(3);
        push_exp("three_items", S_PLAY, 0, 0, 0, 3'd3, 16'h0003, 0);
        items(9);
        push_exp("bcd_carry_0012", S_PLAY, 0, 0, 0, 3'd3, 16'h0012, 0);

        cyc(0, 1, 0, 0);
        push_exp("enemy_lives3", S_DYING, 1, 0, 0, 3'd2, 16'h0012, 0);
        cyc(1, 1, 1, 0);
        push_exp("dying_entry_ignored", S_DYING, 1, 0, 0, 3'd2, 16'h0012, 0);
        frames(59);
        push_exp("dying_59_frames", S_DYING, 1, 0, 0, 3'd2, 16'h0012, 0);
        cyc(1, 0, 0, 0);
        push_exp("dying_60_respawn", S_PLAY, 0, 1, 0, 3'd2, 16'h0012, 0);

        cyc(0, 1, 1, 0);
        push_exp("enemy_item_same", S_DYING, 1, 0, 0, 3'd1, 16'h0012, 0);
        cyc(0, 0, 0, 0);
        frames(59);
        cyc(1, 0, 0, 0);
        push_exp("dying2_respawn", S_PLAY, 0, 1, 0, 3'd1, 16'h0012, 0);

        cyc(0, 0, 0, 1);
        push_exp("goal_levelup", S_LEVEL_UP, 1, 0, 1, 3'd1, 16'h0022, 0);
        cyc(0, 0, 0, 0);
        push_exp("next_level_one_cycle", S_LEVEL_UP, 1, 0, 0, 3'd1, 16'h0022, 0);
        frames(89);
        push_exp("levelup_89_frames", S_LEVEL_UP, 1, 0, 0, 3'd1, 16'h0022, 0);
        cyc(1, 0, 0, 0);
        push_exp("levelup_90_respawn", S_PLAY, 0, 1, 0, 3'd1, 16'h0022, 0);

        items(27);
        push_exp("score_0049", S_PLAY, 0, 0, 0, 3'd1, 16'h0049, 0);
        items(1);
        push_exp("cross_0050", S_PLAY, 0, 0, 0, 3'd1 + BL, 16'h0050, 0);
        items(9945);
        push_exp("score_9995", S_PLAY, 0, 0, 0, 3'd1 + BL, 16'h9995, 0);
        cyc(0, 0, 0, 1);
        push_exp("goal_saturate", S_LEVEL_UP, 1, 0, 1, 3'd1 + BL, 16'h9999, 0);
        cyc(0, 0, 0, 0);
        frames(89);
        cyc(1, 0, 0, 0);
        push_exp("levelup2_respawn", S_PLAY, 0, 1, 0, 3'd1 + BL, 16'h9999, 0);
        items(1);
        push_exp("item_saturate", S_PLAY, 0, 0, 0, 3'd1 + BL, 16'h9999, 0);

`ifdef KONG_BONUS_LIFE_EN
        cyc(0, 1, 0, 0);
        push_exp("bonus_extra_death", S_DYING, 1, 0, 0, 3'd1, 16'h9999, 0);
        cyc(0, 0, 0, 0);
        frames(59);
        cyc(1, 0, 0, 0);
        push_exp("bonus_extra_respawn", S_PLAY, 0, 1, 0, 3'd1, 16'h9999, 0);
`endif

        cyc(0, 1, 0, 0);
        push_exp("fatal_hit", S_GAME_OVER, 1, 0, 0, 3'd0, 16'h9999, 1);
        cyc(0, 1, 1, 1);
        push_exp("game_over_hold", S_GAME_OVER, 1, 0, 0, 3'd0, 16'h9999, 1);
        start_key = 1'b0; cyc(0, 0, 0, 0);
        start_key = 1'b1; cyc(0, 0, 0, 0);
        push_exp("over_to_title", S_TITLE, 1, 0, 0, 3'd0, 16'h9999, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        push_exp("held_key_no_start", S_TITLE, 1, 0, 0, 3'd0, 16'h9999, 0);
        start_key = 1'b0; cyc(0, 0, 0, 0);
        start_key = 1'b1; cyc(0, 0, 0, 0);
        push_exp("title_to_play", S_PLAY, 0, 1, 0, 3'd3, 16'h0000, 0);

        items(50);
        push_exp("bonus_second_game", S_PLAY, 0, 0, 0, 3'd3 + BL, 16'h0050, 0);

        cyc(0, 0, 0, 1);
        resetN = 1'b0; start_key = 1'b0;
        #1 push_exp("mid_reset", S_TITLE, 1, 0, 0, 3'd3, 16'h0000, 0);
        @(posedge clk); #1 resetN = 1'b1;
        cyc(0, 0, 0, 0);
        push_exp("after_reset_title", S_TITLE, 1, 0, 0, 3'd3, 16'h0000, 0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
